// File: rtl/timer.sv
// timer: memory-mapped machine timer with an 8-bit prescaler, compare match,
// optional auto-reload and a sticky pending flag that drives bit 0 of the
// interrupt-flag bus. There are three word registers: CTRL (0x0),
// COUNT (0x4) and CMP (0x8). Address 0xC is unmapped.
//
// Bus handshake: req_i is a one-cycle strobe. The block never stalls.
// ack_o pulses exactly one cycle after each accepted req_i. On a read,
// data_o is valid in that ack cycle and holds until the next read.
module timer #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 32,
   parameter int INT_BUS = 8
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   input  logic               req_i,
   input  logic               we_i,
   input  logic [ADDR_W-1:0]  addr_i,
   input  logic [DATA_W-1:0]  data_i,
   output logic [DATA_W-1:0]  data_o,
   output logic               ack_o,
   output logic [INT_BUS-1:0] int_flag_o
);

   localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

   // CTRL fields
   logic              en;
   logic              ie;
   logic              pend;
   logic              auto_rl;
   logic [7:0]        presc;

   logic [DATA_W-1:0] count;
   logic [DATA_W-1:0] cmp;
   logic [7:0]        psc_cnt;

   logic [1:0]        sel;
   logic              wr_ctrl;
   logic              wr_count;
   logic              wr_cmp;
   logic              rd;
   logic              tick;
   logic              match;
   logic              psc_restart;
   logic [DATA_W-1:0] ctrl_val;
   logic [DATA_W-1:0] rd_val;
   logic              unused_addr;

   // Only addr_i[3:2] selects a register; the remaining address bits are ignored.
   assign unused_addr = ^{addr_i[ADDR_W-1:4], addr_i[1:0]};

   assign sel      = addr_i[3:2];
   assign wr_ctrl  = req_i & we_i & (sel == 2'd0);
   assign wr_count = req_i & we_i & (sel == 2'd1);
   assign wr_cmp   = req_i & we_i & (sel == 2'd2);
   assign rd       = req_i & ~we_i;

   // A tick closes each prescaler period. The match test uses the CMP value
   // held before any write in this same cycle.
   assign tick  = en & (psc_cnt == presc);
   assign match = tick & (count == cmp);

   // Changing PRESC or clearing EN restarts the prescaler period.
   assign psc_restart = wr_ctrl & ((data_i[15:8] != presc) | ~data_i[0]);

   // Assemble the CTRL read image. Unused bits read as zero.
   always_comb begin
      ctrl_val       = '0;
      ctrl_val[0]    = en;
      ctrl_val[1]    = ie;
      ctrl_val[2]    = pend;
      ctrl_val[3]    = auto_rl;
      ctrl_val[15:8] = presc;
   end

   // Read-data multiplexer. The unmapped slot returns zero.
   always_comb begin
      rd_val = '0;
      case (sel)
         2'd0:    rd_val = ctrl_val;
         2'd1:    rd_val = count;
         2'd2:    rd_val = cmp;
         default: rd_val = '0;
      endcase
   end

   // CTRL configuration bits. PEND is handled separately because of its set/clear rules.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         en      <= 1'b0;
         ie      <= 1'b0;
         auto_rl <= 1'b0;
         presc   <= 8'd0;
      end else if (wr_ctrl) begin
         en      <= data_i[0];
         ie      <= data_i[1];
         auto_rl <= data_i[3];
         presc   <= data_i[15:8];
      end
   end

   // Sticky pending flag. A match sets it and wins over a simultaneous write-1-to-clear.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         pend <= 1'b0;
      end else if (match) begin
         pend <= 1'b1;
      end else if (wr_ctrl && data_i[2]) begin
         pend <= 1'b0;
      end
   end

   // Prescaler: counts 0..PRESC while enabled and is held at zero otherwise.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         psc_cnt <= 8'd0;
      end else if (psc_restart || !en || tick) begin
         psc_cnt <= 8'd0;
      end else begin
         psc_cnt <= psc_cnt + 8'd1;
      end
   end

   // Main counter. A bus write takes priority over the tick update.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         count <= '0;
      end else if (wr_count) begin
         count <= data_i;
      end else if (tick) begin
         count <= (match && auto_rl) ? '0 : count + ONE;
      end
   end

   // Compare register. It resets to all-ones so a freshly enabled timer does not match at zero.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         cmp <= '1;
      end else if (wr_cmp) begin
         cmp <= data_i;
      end
   end

   // Bus response: one ack per access. Read data is captured and held until the next read.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         ack_o  <= 1'b0;
         data_o <= '0;
      end else begin
         ack_o <= req_i;
         if (rd) begin
            data_o <= rd_val;
         end
      end
   end

   // Interrupt flags are decoded from registers only. Only bit 0 is ever driven high.
   always_comb begin
      int_flag_o    = '0;
      int_flag_o[0] = pend & ie;
   end

endmodule

// File: tb/tb_timer.sv
// tb_timer: directed bench for the timer. It covers reset values, the
// interrupt latency, prescaled auto-reload, 32-bit wrap, simultaneous
// bus/tick events and reset in the middle of a count.
module tb_timer;

   localparam int DATA_W  = 32;
   localparam int ADDR_W  = 32;
   localparam int INT_BUS = 8;

   localparam logic [ADDR_W-1:0] A_CTRL  = 32'h0;
   localparam logic [ADDR_W-1:0] A_COUNT = 32'h4;
   localparam logic [ADDR_W-1:0] A_CMP   = 32'h8;
   localparam logic [ADDR_W-1:0] A_NONE  = 32'hC;

   // ---------------- clock / reset ----------------
   logic               clk;
   logic               rst_n;
   logic               req;
   logic               we;
   logic [ADDR_W-1:0]  addr;
   logic [DATA_W-1:0]  wdata;
   logic [DATA_W-1:0]  rdata;
   logic               ack;
   logic [INT_BUS-1:0] int_flag;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   timer #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .INT_BUS(INT_BUS)
   ) dut (
      .clk_i     (clk),
      .rst_n_i   (rst_n),
      .req_i     (req),
      .we_i      (we),
      .addr_i    (addr),
      .data_i    (wdata),
      .data_o    (rdata),
      .ack_o     (ack),
      .int_flag_o(int_flag)
   );

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_fail   = 0;
   logic [DATA_W-1:0] exp_q[$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance to one time unit after the next rising edge.
   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // ---------------- driver tasks ----------------
   // Each access occupies the current cycle. The task returns in the ack cycle.
   task automatic write_reg(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      req = 1'b1; we = 1'b1; addr = a; wdata = d;
      step(1);
      req = 1'b0; we = 1'b0;
      check_eq("write_ack", {31'b0, ack}, 32'h1);
   endtask

   task automatic read_reg(input string tag, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] e);
      logic [DATA_W-1:0] exp_v;
      exp_q.push_back(e);
      req = 1'b1; we = 1'b0; addr = a;
      step(1);
      req = 1'b0;
      check_eq({tag, "_ack"}, {31'b0, ack}, 32'h1);
      exp_v = exp_q.pop_front();
      check_eq(tag, rdata, exp_v);
   endtask

   task automatic check_flag(input string tag, input logic bit0);
      check_eq(tag, {24'b0, int_flag}, {31'b0, bit0});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------- stimulus ----------------
   initial begin
      rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
      step(3);
      rst_n = 1'b1;

      // Reset state
      check_flag("rst_flag", 1'b0);
      check_eq("rst_ack", {31'b0, ack}, 32'h0);
      check_eq("rst_data", rdata, 32'h0);
      read_reg("rst_ctrl",  A_CTRL,  32'h0);
      read_reg("rst_count", A_COUNT, 32'h0);
      read_reg("rst_cmp",   A_CMP,   32'hFFFF_FFFF);
      read_reg("rst_none",  A_NONE,  32'h0);
      write_reg(A_NONE, 32'hDEAD_BEEF);
      read_reg("none_wr",   A_NONE,  32'h0);

      // Interrupt latency: CMP=5, EN|IE written at cycle t
      write_reg(A_CMP, 32'd5);
      write_reg(A_CTRL, 32'h3);                 // now at t+1
      for (int k = 1; k <= 7; k++) begin
         check_flag($sformatf("irq_lat_%0d", k), k == 7);
         if (k < 7) step(1);
      end                                       // at t+7, COUNT=6
      read_reg("irq_cnt6", A_COUNT, 32'd6);
      read_reg("irq_cnt7", A_COUNT, 32'd7);
      check_flag("irq_held", 1'b1);
      read_reg("irq_ctrl", A_CTRL, 32'h7);
      write_reg(A_CTRL, 32'h7);                 // W1C PEND
      check_flag("irq_clr", 1'b0);
      read_reg("irq_ctrl_clr", A_CTRL, 32'h3);

      // Prescaled auto-reload: CMP=3, EN|AUTO, PRESC=2
      write_reg(A_CTRL, 32'h0);
      write_reg(A_COUNT, 32'h0);
      write_reg(A_CMP, 32'd3);
      write_reg(A_CTRL, 32'h0209);              // now at t+1
      for (int k = 1; k <= 15; k++) begin
         read_reg($sformatf("ar_cnt_%0d", k), A_COUNT, ((k - 1) / 3) % 4);
      end                                       // t+16
      read_reg("ar_pend1", A_CTRL, 32'h020D);   // t+16
      write_reg(A_CTRL, 32'h020D);              // t+17 W1C
      read_reg("ar_clr", A_CTRL, 32'h0209);     // t+18
      step(6);                                  // t+25
      check_flag("ar_no_ie", 1'b0);
      read_reg("ar_pend2", A_CTRL, 32'h020D);   // t+25
      write_reg(A_CTRL, 32'h020D);              // t+26 W1C
      step(9);                                  // t+36 = match tick
      write_reg(A_CTRL, 32'h020D);              // W1C in match cycle
      read_reg("sim_w1c", A_CTRL, 32'h020D);    // set wins

      // 32-bit wrap: COUNT=0xFFFFFFFE, CMP=0
      write_reg(A_CTRL, 32'h4);
      write_reg(A_COUNT, 32'hFFFF_FFFE);
      write_reg(A_CMP, 32'h0);
      write_reg(A_CTRL, 32'h1);                 // u -> u+1
      read_reg("wrap_fe", A_COUNT, 32'hFFFF_FFFE);
      read_reg("wrap_ff", A_COUNT, 32'hFFFF_FFFF);
      read_reg("wrap_nopend", A_CTRL, 32'h1);   // COUNT=0 tick here
      read_reg("wrap_pend", A_CTRL, 32'h5);
      read_reg("wrap_cnt2", A_COUNT, 32'd2);

      // Simultaneous CMP / COUNT writes in tick cycles
      write_reg(A_CTRL, 32'h4);
      write_reg(A_CMP, 32'hFFFF_FFFF);
      write_reg(A_COUNT, 32'h0);
      write_reg(A_CTRL, 32'h1);                 // w -> w+1, COUNT=0 tick
      write_reg(A_CMP, 32'h0);                  // compare uses old CMP
      read_reg("sim_cmp", A_CTRL, 32'h1);
      write_reg(A_COUNT, 32'h100);              // in a tick cycle
      read_reg("sim_cnt", A_COUNT, 32'h100);
      read_reg("sim_cnt_inc", A_COUNT, 32'h101);

      // Reset with EN, IE, PEND set
      write_reg(A_CTRL, 32'h4);
      write_reg(A_COUNT, 32'h0);
      write_reg(A_CMP, 32'd2);
      write_reg(A_CTRL, 32'h3);                 // x -> x+1
      step(4);                                  // x+5, PEND set at x+4
      check_flag("pre_rst_flag", 1'b1);
      rst_n = 1'b0;
      step(1);
      rst_n = 1'b1;
      check_flag("mid_rst_flag", 1'b0);
      check_eq("mid_rst_ack", {31'b0, ack}, 32'h0);
      check_eq("mid_rst_data", rdata, 32'h0);
      read_reg("mid_rst_ctrl", A_CTRL, 32'h0);
      read_reg("mid_rst_cnt", A_COUNT, 32'h0);
      step(3);
      read_reg("mid_rst_frozen", A_COUNT, 32'h0);
      read_reg("mid_rst_cmp", A_CMP, 32'hFFFF_FFFF);
      check_flag("mid_rst_flag2", 1'b0);

      // Final report
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
